// File: rtl/dottori_pkg.sv
// dottori_pkg: shared sequencer state type and ROM geometry for the Dottori-Kun loader.
package dottori_pkg;
    typedef enum logic [2:0] {ST_HOLD, ST_RUN, ST_ARM, ST_LOAD, ST_FINISH} state_t;
    localparam int ROM_AW_DEF = 14;
    localparam int ROM_SIZE = 1 << ROM_AW_DEF;
endpackage

// File: rtl/rom_wr_stage.sv
// rom_wr_stage: one-deep ROM write staging register with byte counter and checksum.
module rom_wr_stage #(
    parameter int AW = 14
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          wr_i,
    input  logic [AW-1:0] addr_i,
    input  logic [7:0]    data_i,
    output logic          we_o,
    output logic [AW-1:0] addr_o,
    output logic [7:0]    data_o,
    output logic [AW:0]   count_o,
    output logic [7:0]    sum_o
);
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [7:0]    data_q;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    sum_q, sum_d;

    // count saturates instead of wrapping so an oversized stream still reads as "too long"
    always_comb begin
        count_d = clr_i ? '0 : (wr_i && count_q != '1) ? count_q + 1'b1 : count_q;
        sum_d = clr_i ? '0 : wr_i ? sum_q + data_i : sum_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            count_q <= '0;
            sum_q <= '0;
        end else begin
            we_q <= wr_i;
            if (wr_i) begin
                addr_q <= addr_i;
                data_q <= data_i;
            end
            count_q <= count_d;
            sum_q <= sum_d;
        end
    end

    assign we_o = we_q;
    assign addr_o = addr_q;
    assign data_o = data_q;
    assign count_o = count_q;
    assign sum_o = sum_q;
endmodule

// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer: arbitrates the ROM port between CPU and HPS download,
// and holds the CPU in reset around loads and reset requests.
module rom_load_sequencer
    import dottori_pkg::*;
#(
    parameter int ROM_AW = ROM_AW_DEF,
    parameter int ARM_CYCLES = 2,
    parameter int HOLD_CYCLES = 16
) (
    input  logic              CLK_4M,
    input  logic              nRESET,
    input  logic              sys_reset,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [ROM_AW:0]   dl_addr,
    input  logic [7:0]        dl_data,
    output logic              dl_wait,
    input  logic [ROM_AW-1:0] cpu_addr,
    output logic              cpu_nreset,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [7:0]        rom_din,
    output logic              rom_we,
    output logic [ROM_AW:0]   byte_count,
    output logic [7:0]        checksum,
    output logic              dl_done,
    output logic              dl_short,
    output logic              dl_range_err
);
    localparam int CMAX = (HOLD_CYCLES > ARM_CYCLES) ? HOLD_CYCLES : ARM_CYCLES;
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] ARM_LAST = CW'(ARM_CYCLES - 1);
    localparam logic [ROM_AW:0] FULL_COUNT = {1'b1, {ROM_AW{1'b0}}};

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              act_q;
    logic              cpu_nreset_q, dl_wait_q, dl_done_q;
    logic              dl_short_q, dl_short_d, range_err_q, range_err_d;
    logic              rise, accept, arm_entry;
    logic [ROM_AW-1:0] stg_addr;

    // act_q resets low so a download already active at reset release is seen as a new one
    assign rise = dl_active && !act_q;
    assign accept = state_q == ST_LOAD && dl_wr;
    assign arm_entry = state_d == ST_ARM && state_q != ST_ARM;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HOLD:   state_d = rise ? ST_ARM : (cnt_q == HOLD_LAST) ? ST_RUN : ST_HOLD;
            ST_RUN:    state_d = rise ? ST_ARM : sys_reset ? ST_HOLD : ST_RUN;
            ST_ARM:    state_d = (cnt_q == ARM_LAST) ? ST_LOAD : ST_ARM;
            ST_LOAD:   state_d = dl_active ? ST_LOAD : ST_FINISH;
            ST_FINISH: state_d = ST_HOLD;
            default:   state_d = ST_HOLD;
        endcase
        cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
        dl_short_d = arm_entry ? 1'b0 : (state_q == ST_FINISH) ? (byte_count != FULL_COUNT) : dl_short_q;
        range_err_d = arm_entry ? 1'b0 : (accept && dl_addr[ROM_AW]) ? 1'b1 : range_err_q;
    end

    always_ff @(posedge CLK_4M or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= ST_HOLD;
            cnt_q <= '0;
            act_q <= 1'b0;
            cpu_nreset_q <= 1'b0;
            dl_wait_q <= 1'b0;
            dl_done_q <= 1'b0;
            dl_short_q <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            act_q <= dl_active;
            cpu_nreset_q <= state_d == ST_RUN;
            dl_wait_q <= state_d == ST_ARM;
            dl_done_q <= state_d == ST_FINISH;
            dl_short_q <= dl_short_d;
            range_err_q <= range_err_d;
        end
    end

    rom_wr_stage #(.AW(ROM_AW)) u_stage (
        .clk_i   (CLK_4M),
        .rst_ni  (nRESET),
        .clr_i   (arm_entry),
        .wr_i    (accept && !dl_addr[ROM_AW]),
        .addr_i  (dl_addr[ROM_AW-1:0]),
        .data_i  (dl_data),
        .we_o    (rom_we),
        .addr_o  (stg_addr),
        .data_o  (rom_din),
        .count_o (byte_count),
        .sum_o   (checksum)
    );

    assign rom_addr = (state_q == ST_LOAD || state_q == ST_FINISH) ? stg_addr : cpu_addr;
    assign cpu_nreset = cpu_nreset_q;
    assign dl_wait = dl_wait_q;
    assign dl_done = dl_done_q;
    assign dl_short = dl_short_q;
    assign dl_range_err = range_err_q;
endmodule

// File: tb/tb_rom_load_sequencer.sv
// tb_rom_load_sequencer: directed checks of power-up hold, arming, full/short loads,
// range errors, sys_reset handling and asynchronous reset during a load.
module tb_rom_load_sequencer;
    logic        CLK_4M, nRESET, sys_reset, dl_active, dl_wr;
    logic [14:0] dl_addr;
    logic [7:0]  dl_data;
    logic        dl_wait, cpu_nreset, rom_we, dl_done, dl_short, dl_range_err;
    logic [13:0] cpu_addr, rom_addr;
    logic [7:0]  rom_din, checksum;
    logic [14:0] byte_count;
    int total = 0;
    int bad = 0;

    rom_load_sequencer #(.ROM_AW(14), .ARM_CYCLES(2), .HOLD_CYCLES(16)) dut (
        .CLK_4M(CLK_4M), .nRESET(nRESET), .sys_reset(sys_reset), .dl_active(dl_active),
        .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .dl_wait(dl_wait),
        .cpu_addr(cpu_addr), .cpu_nreset(cpu_nreset), .rom_addr(rom_addr), .rom_din(rom_din),
        .rom_we(rom_we), .byte_count(byte_count), .checksum(checksum), .dl_done(dl_done),
        .dl_short(dl_short), .dl_range_err(dl_range_err)
    );

    initial CLK_4M = 1'b0;
    always #5 CLK_4M = ~CLK_4M;

    task automatic tick();
        @(posedge CLK_4M);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_run(output int n);
        n = 0;
        while (cpu_nreset !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
    endtask

    task automatic arm(input string tag);
        dl_active = 1'b1;
        tick();
        chk({tag, "_wait1"}, dl_wait, 1);
        chk({tag, "_nrst"}, cpu_nreset, 0);
        chk({tag, "_bc_clr"}, byte_count, 0);
        chk({tag, "_cs_clr"}, checksum, 0);
        tick();
        chk({tag, "_wait2"}, dl_wait, 1);
        tick();
        chk({tag, "_wait_end"}, dl_wait, 0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_nrst"}, cpu_nreset, 0);
        chk({tag, "_we"}, rom_we, 0);
        chk({tag, "_wait"}, dl_wait, 0);
        chk({tag, "_done"}, dl_done, 0);
        chk({tag, "_bc"}, byte_count, 0);
        chk({tag, "_cs"}, checksum, 0);
        chk({tag, "_short"}, dl_short, 0);
        chk({tag, "_rerr"}, dl_range_err, 0);
    endtask

    initial begin
        int n, wecnt, errs;
        nRESET = 1'b0; sys_reset = 1'b0; dl_active = 1'b0; dl_wr = 1'b0;
        dl_addr = '0; dl_data = '0; cpu_addr = 14'h1234;
        tick(); tick();
        check_reset_values("por");
        chk("por_romaddr", rom_addr, 14'h1234);
        nRESET = 1'b1;
        wait_run(n);
        chk("por_hold_len", n, 16);
        chk("run_romaddr", rom_addr, 14'h1234);
        chk("run_we", rom_we, 0);

        // full load, first byte held under dl_wait
        dl_wr = 1'b1; dl_addr = 15'd0; dl_data = 8'd0;
        arm("arm_full");
        wecnt = 0; errs = 0;
        for (int i = 0; i < 16384; i++) begin
            dl_addr = 15'(i); dl_data = 8'(i);
            sys_reset = (i == 5000);
            tick();
            if (rom_we === 1'b1) wecnt++;
            if (rom_we !== 1'b1 || rom_addr !== 14'(i) || rom_din !== 8'(i) || cpu_nreset !== 1'b0 || dl_wait !== 1'b0 || dl_done !== 1'b0) errs++;
        end
        sys_reset = 1'b0;
        chk("full_we_count", wecnt, 16384);
        chk("full_step_errs", errs, 0);
        dl_wr = 1'b0; dl_active = 1'b0;
        tick();
        chk("full_done", dl_done, 1);
        chk("full_we_off", rom_we, 0);
        chk("full_bc", byte_count, 15'h4000);
        chk("full_cs", checksum, 8'h00);
        tick();
        chk("full_done_pulse", dl_done, 0);
        chk("full_short", dl_short, 0);
        wait_run(n);
        chk("full_hold_len", n, 16);

        // short load; last byte coincides with dl_active falling so FINISH commits it
        dl_wr = 1'b0;
        arm("arm_short");
        dl_wr = 1'b1; dl_data = 8'h01;
        for (int i = 0; i < 100; i++) begin
            dl_addr = 15'(i);
            if (i == 99) dl_active = 1'b0;
            tick();
        end
        dl_wr = 1'b0;
        chk("short_done", dl_done, 1);
        chk("short_fin_we", rom_we, 1);
        chk("short_fin_addr", rom_addr, 14'd99);
        chk("short_bc", byte_count, 15'd100);
        chk("short_cs", checksum, 8'h64);
        tick();
        chk("short_flag", dl_short, 1);
        chk("short_done_pulse", dl_done, 0);
        wait_run(n);
        chk("short_hold_len", n, 16);

        // range error
        arm("arm_range");
        chk("range_short_clr", dl_short, 0);
        dl_wr = 1'b1; dl_addr = 15'h4000; dl_data = 8'hAA;
        tick();
        chk("range_we", rom_we, 0);
        chk("range_err", dl_range_err, 1);
        chk("range_cs", checksum, 8'h00);
        chk("range_bc", byte_count, 0);
        dl_addr = 15'd5; dl_data = 8'h10;
        tick();
        chk("range_ok_we", rom_we, 1);
        chk("range_ok_addr", rom_addr, 14'd5);
        chk("range_ok_din", rom_din, 8'h10);
        chk("range_ok_cs", checksum, 8'h10);
        chk("range_ok_bc", byte_count, 15'd1);
        dl_wr = 1'b0; dl_active = 1'b0;
        tick();
        chk("range_done", dl_done, 1);
        wait_run(n);
        chk("range_hold_len", n, 17);

        // dl_wr in RUN is dropped
        dl_wr = 1'b1; dl_addr = 15'h10; dl_data = 8'h55;
        tick();
        dl_wr = 1'b0;
        chk("run_wr_we", rom_we, 0);
        chk("run_wr_bc", byte_count, 15'd1);
        chk("run_wr_cs", checksum, 8'h10);
        chk("run_rerr_sticky", dl_range_err, 1);

        // sys_reset in RUN
        sys_reset = 1'b1;
        tick();
        sys_reset = 1'b0;
        chk("sysrst_nrst", cpu_nreset, 0);
        wait_run(n);
        chk("sysrst_hold_len", n, 16);

        // reset mid-load
        arm("arm_mid");
        chk("mid_rerr_clr", dl_range_err, 0);
        dl_wr = 1'b1; dl_data = 8'h02;
        for (int i = 0; i < 50; i++) begin
            dl_addr = 15'(i);
            tick();
        end
        dl_addr = 15'd50;
        chk("mid_bc", byte_count, 15'd50);
        chk("mid_cs", checksum, 8'h64);
        chk("mid_we", rom_we, 1);
        nRESET = 1'b0;
        #1;
        check_reset_values("mid_rst");
        dl_wr = 1'b0;
        tick();
        check_reset_values("mid_rst_hold");

        // dl_active high at release is a rising edge
        nRESET = 1'b1;
        tick();
        chk("rel_arm_wait", dl_wait, 1);
        chk("rel_arm_nrst", cpu_nreset, 0);
        dl_active = 1'b0;
        n = 0;
        while (dl_done !== 1'b1 && n < 16) begin
            tick();
            n++;
        end
        chk("rel_done_lat", n, 3);
        tick();
        chk("rel_short", dl_short, 1);
        wait_run(n);
        chk("rel_hold_len", n, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rom_load_sequencer.md
# rom_load_sequencer

Sequences program-ROM loading and CPU reset for the Dottori-Kun core. Sits between the HPS download stream and the dottori game block. Owns the single ROM write/address port: the CPU holds it while running, the loader holds it during a download. Also generates the CPU reset with a guaranteed hold time, and reports byte count, checksum and length/range errors.

## Interface
Parameters:
- ROM_AW, 14, ROM address width; ROM_SIZE = 2^ROM_AW bytes
- ARM_CYCLES, 2, cycles CPU is held in reset before the loader takes the port
- HOLD_CYCLES, 16, cycles CPU is held in reset after a load or reset request (≥1)

Ports:
- CLK_4M  in  1  system clock
- nRESET  in  1  asynchronous active-low reset
- sys_reset  in  1  synchronous active-high reset request (OSD/button)
- dl_active  in  1  download of index 0 in progress
- dl_wr  in  1  download byte strobe
- dl_addr  in  ROM_AW+1  download byte address
- dl_data  in  8  download byte
- dl_wait  out  1  host must hold dl_wr/addr/data
- cpu_addr  in  ROM_AW  CPU ROM address
- cpu_nreset  out  1  CPU reset, active low
- rom_addr  out  ROM_AW  ROM port address
- rom_din  out  8  ROM write data
- rom_we  out  1  ROM write enable
- byte_count  out  ROM_AW+1  accepted bytes in last/current load
- checksum  out  8  modulo-256 sum of accepted bytes
- dl_done  out  1  one-cycle pulse at end of load
- dl_short  out  1  sticky: last load count ≠ ROM_SIZE
- dl_range_err  out  1  sticky: a write had dl_addr ≥ ROM_SIZE

## Operation
- States: HOLD, RUN, ARM, LOAD, FINISH. On nRESET low: state HOLD, hold counter 0, cpu_nreset=0, rom_we=0, dl_wait=0, dl_done=0, byte_count=0, checksum=0, flags=0, staging register empty.
- HOLD: cpu_nreset=0. Counter runs HOLD_CYCLES, then RUN. A rising edge on dl_active goes to ARM; this takes priority.
- RUN: cpu_nreset=1. rom_addr=cpu_addr, rom_we=0. A rising edge on dl_active goes to ARM. Otherwise sys_reset goes to HOLD with the counter cleared.
- ARM: cpu_nreset=0 and dl_wait=1. On entry: byte_count, checksum, dl_short and dl_range_err are cleared. After ARM_CYCLES, go to LOAD.
- LOAD: cpu_nreset=0 and dl_wait=0. Each dl_wr is one accepted byte.
  - In range (dl_addr < ROM_SIZE): latch addr/data into the staging register. Next cycle drive rom_we=1 with rom_addr/rom_din. byte_count+1; checksum+data, wrapping.
  - Out of range: drop the byte, set dl_range_err, byte_count and checksum unchanged.
  - Back-to-back dl_wr is accepted every cycle.
  - sys_reset is ignored.
  - dl_active low goes to FINISH.
- FINISH: commits any staged write (rom_we may be high this cycle). Pulses dl_done. Sets dl_short = (byte_count ≠ ROM_SIZE). Then goes to HOLD with the counter cleared.
- dl_wr outside LOAD is dropped with no side effect. The host honours dl_wait.
- dl_active already high when nRESET releases counts as a rising edge: HOLD goes to ARM.
- Duplicate addresses are written again and counted again.
- byte_count saturates at 2^(ROM_AW+1)−1.

## Timing
- dl_active rises at cycle t (RUN): cpu_nreset=0 at t+1, dl_wait=1 for t+1..t+ARM_CYCLES. The first byte can be accepted at t+ARM_CYCLES+1.
- A dl_wr accepted at cycle t gives rom_we=1 at t+1. byte_count and checksum update at t+1.
- dl_active falls at cycle f (LOAD): FINISH at f+1 with dl_done=1, HOLD from f+2. cpu_nreset goes to 1 at f+2+HOLD_CYCLES.
- sys_reset in RUN at cycle t: cpu_nreset=0 at t+1, back to 1 at t+1+HOLD_CYCLES.
- nRESET asserted mid-load: state goes immediately to HOLD and all outputs to reset values. The staged write is lost.
- All outputs are registered except rom_addr, which is muxed combinationally from the state register.

## Structure
- Shared package dottori_pkg: state enum, ROM_AW default, ROM_SIZE localparam.
- One sub-module: rom_wr_stage (staging register plus count/checksum accumulator). The FSM and counter stay in the top.

## Test plan
- Power-up: release nRESET with dl_active=0 → cpu_nreset=0 for 16 cycles, then 1. rom_addr follows cpu_addr=0x1234.
- Full load: 16384 bytes, data=addr[7:0], one per cycle → 16384 rom_we pulses each one cycle after its dl_wr, byte_count=16384, checksum=0x00, dl_short=0, dl_done one pulse.
- Short load: 100 bytes of 0x01 → byte_count=100, checksum=0x64, dl_short=1, CPU released 16 cycles after FINISH.
- Range: write dl_addr=0x4000 with data 0xAA → no rom_we, dl_range_err=1, checksum unchanged. Next ARM clears the flag.
- Arming: dl_active rises while in RUN → dl_wait=1 for exactly 2 cycles and cpu_nreset low from the next cycle. A dl_wr held under wait is accepted once.
- Reset mid-load: nRESET low after 50 bytes → all outputs at reset values. sys_reset pulse during LOAD → no effect.
